// File: rtl/axi4lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and write-master FSM state encodings.
package axi4lite_pkg;

  typedef logic [1:0] axi_resp_t;
  typedef logic [1:0] mst_state_t;

  // Response codes carried on bresp/rresp
  localparam axi_resp_t OKAY   = 2'b00;
  localparam axi_resp_t EXOKAY = 2'b01;
  localparam axi_resp_t SLVERR = 2'b10;
  localparam axi_resp_t DECERR = 2'b11;

  // Write-master FSM states
  localparam mst_state_t MST_IDLE = 2'b00;
  localparam mst_state_t MST_SEND = 2'b01;
  localparam mst_state_t MST_RESP = 2'b10;

  // True for the two error responses (SLVERR, DECERR)
  function automatic logic resp_is_error(input axi_resp_t r);
    return r[1];
  endfunction

endpackage

// File: rtl/axi4lite_watchdog.sv
// Saturating in-flight cycle counter with a sticky expiry flag.
// clear has priority over run; expired rises on the edge the count reaches TIMEOUT.
module axi4lite_watchdog #(
  parameter int TIMEOUT = 8
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count_reg;

  // Count in-flight cycles, saturate at TIMEOUT, latch expiry until the next clear
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      count_reg <= '0;
      expired   <= 1'b0;
    end else if (clear) begin
      count_reg <= '0;
      expired   <= 1'b0;
    end else if (run) begin
      if (count_reg != CNT_MAX) begin
        count_reg <= count_reg + CNT_W'(1);
      end
      if (count_reg >= CNT_LAST) begin
        expired <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi4lite_write_master.sv
// AXI4-Lite write initiator: one single-beat write in flight, AW and W driven
// independently, B collected and returned to the local requester with a done pulse.
module axi4lite_write_master
  import axi4lite_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 0
) (
  input  logic                aclk,
  input  logic                aresetn,
  // local request side
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_data,
  input  logic [DATA_W/8-1:0] req_strb,
  input  logic [2:0]          req_prot,
  output logic                done,
  output logic [1:0]          resp,
  output logic                timeout,
  // AW channel
  output logic                awvalid,
  input  logic                awready,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [2:0]          awprot,
  // W channel
  output logic                wvalid,
  input  logic                wready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  // B channel
  input  logic                bvalid,
  output logic                bready,
  input  logic [1:0]          bresp
);

  mst_state_t state_reg;
  logic       aw_done_reg;
  logic       w_done_reg;

  logic aw_hs;
  logic w_hs;
  logic aw_fin;
  logic w_fin;
  logic accept;
  logic wd_expired;

  assign aw_hs  = awvalid & awready;
  assign w_hs   = wvalid & wready;
  // A channel counts as finished if it completed earlier or completes this cycle
  assign aw_fin = aw_done_reg | aw_hs;
  assign w_fin  = w_done_reg | w_hs;
  assign accept = (state_reg == MST_IDLE) & req_valid & req_ready;

  // Transaction FSM: payload latch, per-channel valid retirement, B collection
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg   <= MST_IDLE;
      aw_done_reg <= 1'b0;
      w_done_reg  <= 1'b0;
      req_ready   <= 1'b1;
      awvalid     <= 1'b0;
      wvalid      <= 1'b0;
      bready      <= 1'b0;
      done        <= 1'b0;
      resp        <= OKAY;
      awaddr      <= '0;
      awprot      <= '0;
      wdata       <= '0;
      wstrb       <= '0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        MST_IDLE: begin
          if (accept) begin
            awaddr      <= req_addr;
            awprot      <= req_prot;
            wdata       <= req_data;
            wstrb       <= req_strb;
            awvalid     <= 1'b1;
            wvalid      <= 1'b1;
            req_ready   <= 1'b0;
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
            state_reg   <= MST_SEND;
          end
        end
        MST_SEND: begin
          if (aw_hs) begin
            awvalid     <= 1'b0;
            aw_done_reg <= 1'b1;
          end
          if (w_hs) begin
            wvalid     <= 1'b0;
            w_done_reg <= 1'b1;
          end
          if (aw_fin && w_fin) begin
            bready    <= 1'b1;
            state_reg <= MST_RESP;
          end
        end
        MST_RESP: begin
          if (bvalid && bready) begin
            bready    <= 1'b0;
            resp      <= bresp;
            done      <= 1'b1;
            req_ready <= 1'b1;
            state_reg <= MST_IDLE;
          end
        end
        default: begin
          // Unreachable encoding: fall back to a clean idle
          awvalid   <= 1'b0;
          wvalid    <= 1'b0;
          bready    <= 1'b0;
          req_ready <= 1'b1;
          state_reg <= MST_IDLE;
        end
      endcase
    end
  end

  // Watchdog only exists when a limit is configured; otherwise the flag is tied low
  generate
    if (TIMEOUT > 0) begin : g_wd
      axi4lite_watchdog #(
        .TIMEOUT (TIMEOUT)
      ) u_watchdog (
        .aclk    (aclk),
        .aresetn (aresetn),
        .clear   (accept),
        .run     (state_reg != MST_IDLE),
        .expired (wd_expired)
      );
    end else begin : g_no_wd
      assign wd_expired = 1'b0;
    end
  endgenerate

  assign timeout = wd_expired;

endmodule

// File: tb/tb_axi4lite_write_master.sv
// Directed bench for axi4lite_write_master with a behavioural slave offering
// AW/W stall control, B withholding and forced responses, plus a response scoreboard.
module tb_axi4lite_write_master;
  import axi4lite_pkg::*;

  logic        aclk;
  logic        aresetn;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [3:0]  req_strb;
  logic [2:0]  req_prot;
  logic        done;
  logic [1:0]  resp;
  logic        timeout;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;

  int checks   = 0;
  int failures = 0;
  logic [1:0] sb_q[$];

  axi4lite_write_master #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (8)
  ) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_strb  (req_strb),
    .req_prot  (req_prot),
    .done      (done),
    .resp      (resp),
    .timeout   (timeout),
    .awvalid   (awvalid),
    .awready   (awready),
    .awaddr    (awaddr),
    .awprot    (awprot),
    .wvalid    (wvalid),
    .wready    (wready),
    .wdata     (wdata),
    .wstrb     (wstrb),
    .bvalid    (bvalid),
    .bready    (bready),
    .bresp     (bresp)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // ---------------- behavioural slave ----------------
  int         aw_stall_cfg = 0;
  int         w_stall_cfg  = 0;
  bit         b_hold       = 1'b0;
  bit         b_force      = 1'b0;
  logic [1:0] b_force_val  = 2'b00;

  int          aw_wait;
  int          w_wait;
  logic        aw_got;
  logic        w_got;
  logic [31:0] s_addr;
  logic [31:0] s_data;
  logic [3:0]  s_strb;
  logic [3:0]  slave_en;

  assign awready  = awvalid && (aw_wait >= aw_stall_cfg);
  assign wready   = wvalid && (w_wait >= w_stall_cfg);
  assign bresp    = b_force ? b_force_val : ((s_addr[1:0] != 2'b00) ? SLVERR : OKAY);
  assign slave_en = (s_addr[1:0] == 2'b00) ? s_strb : 4'h0;

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_wait <= 0;
      w_wait  <= 0;
      aw_got  <= 1'b0;
      w_got   <= 1'b0;
      bvalid  <= 1'b0;
      s_addr  <= '0;
      s_data  <= '0;
      s_strb  <= '0;
    end else begin
      aw_wait <= (awvalid && !awready) ? aw_wait + 1 : 0;
      w_wait  <= (wvalid && !wready) ? w_wait + 1 : 0;
      if (bvalid && bready) begin
        bvalid <= 1'b0;
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end else begin
        if (awvalid && awready) begin
          aw_got <= 1'b1;
          s_addr <= awaddr;
        end
        if (wvalid && wready) begin
          w_got  <= 1'b1;
          s_data <= wdata;
          s_strb <= wstrb;
        end
        if ((aw_got || (awvalid && awready)) && (w_got || (wvalid && wready)) && !bvalid && !b_hold)
          bvalid <= 1'b1;
      end
    end
  end

  // ---------------- event counters ----------------
  int aw_hs_total = 0;
  int w_hs_total  = 0;
  int done_total  = 0;

  always @(posedge aclk) begin
    if (awvalid && awready) aw_hs_total <= aw_hs_total + 1;
    if (wvalid && wready)   w_hs_total  <= w_hs_total + 1;
    if (done)               done_total  <= done_total + 1;
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one request for a single accept edge and record its expected response
  task automatic do_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input logic [2:0] p, input logic [1:0] exp_r);
    int n;
    n = 0;
    while (!req_ready && n < 50) begin
      tick();
      n++;
    end
    req_addr  = a;
    req_data  = d;
    req_strb  = s;
    req_prot  = p;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    sb_q.push_back(exp_r);
  endtask

  // Wait (bounded) for done, tally channel activity, compare resp against the scoreboard
  task automatic wait_done(input string tag, input int max_cyc, output int lat,
                           output int aw_cyc, output int w_cyc,
                           output bit early_b, output bit addr_moved);
    logic [31:0] a0;
    bit seen;
    logic [1:0] exp_r;
    lat = 0; aw_cyc = 0; w_cyc = 0; early_b = 0; addr_moved = 0; seen = 0;
    a0 = awaddr;
    for (int i = 0; i < max_cyc; i++) begin
      if (awvalid) aw_cyc++;
      if (wvalid) w_cyc++;
      if (awvalid && awaddr !== a0) addr_moved = 1;
      if (bready && awvalid) early_b = 1;
      tick();
      lat++;
      if (done) begin
        seen = 1;
        break;
      end
    end
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    if (seen) begin
      exp_r = (sb_q.size() > 0) ? sb_q.pop_front() : 2'bxx;
      check({tag, "_resp"}, 64'(resp), 64'(exp_r));
      tick();
      check({tag, "_done_single"}, 64'(done), 64'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  int lat, awc, wc, d0, a0, w0;
  bit eb, am;

  initial begin
    aresetn   = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_data  = '0;
    req_strb  = '0;
    req_prot  = '0;
    repeat (3) @(posedge aclk);
    #1;
    // reset state
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_awvalid", 64'(awvalid), 64'd0);
    check("rst_wvalid", 64'(wvalid), 64'd0);
    check("rst_bready", 64'(bready), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_timeout", 64'(timeout), 64'd0);
    check("rst_resp", 64'(resp), 64'd0);
    check("rst_awaddr", 64'(awaddr), 64'd0);
    check("rst_wdata", 64'(wdata), 64'd0);
    aresetn = 1'b1;
    tick();

    // 1: basic write, minimum latency
    d0 = done_total;
    do_req(32'h10, 32'hDEADBEEF, 4'hF, 3'b010, OKAY);
    check("t1_awvalid", 64'(awvalid), 64'd1);
    check("t1_wvalid", 64'(wvalid), 64'd1);
    check("t1_req_ready", 64'(req_ready), 64'd0);
    check("t1_awaddr", 64'(awaddr), 64'h10);
    check("t1_awprot", 64'(awprot), 64'd2);
    check("t1_wdata", 64'(wdata), 64'hDEADBEEF);
    check("t1_wstrb", 64'(wstrb), 64'hF);
    wait_done("t1", 40, lat, awc, wc, eb, am);
    check("t1_accept_to_done", 64'(lat + 1), 64'd3);
    check("t1_slave_data", 64'(s_data), 64'hDEADBEEF);
    check("t1_slave_en", 64'(slave_en), 64'hF);
    check("t1_done_count", 64'(done_total - d0), 64'd1);
    $display("txn t1 addr=10 resp=%0d lat=%0d", resp, lat + 1);

    // 2: AW stalled 3 cycles, W immediate
    aw_stall_cfg = 3;
    d0 = done_total;
    do_req(32'h24, 32'h01234567, 4'h3, 3'b000, OKAY);
    wait_done("t2", 40, lat, awc, wc, eb, am);
    check("t2_aw_cycles", 64'(awc), 64'd4);
    check("t2_w_cycles", 64'(wc), 64'd1);
    check("t2_awaddr_stable", 64'(am), 64'd0);
    check("t2_bready_early", 64'(eb), 64'd0);
    check("t2_done_count", 64'(done_total - d0), 64'd1);
    aw_stall_cfg = 0;
    $display("txn t2 addr=24 aw_cycles=%0d w_cycles=%0d", awc, wc);

    // 3: misaligned address -> SLVERR from slave
    d0 = done_total;
    do_req(32'h13, 32'hCAFEF00D, 4'hF, 3'b000, SLVERR);
    wait_done("t3", 40, lat, awc, wc, eb, am);
    check("t3_slave_en", 64'(slave_en), 64'd0);
    check("t3_done_count", 64'(done_total - d0), 64'd1);
    $display("txn t3 addr=13 resp=%0d", resp);

    // 4: watchdog with B withheld, then DECERR
    b_hold = 1'b1;
    do_req(32'h40, 32'h55AA55AA, 4'hF, 3'b000, DECERR);
    repeat (7) tick();
    check("t4_timeout_before", 64'(timeout), 64'd0);
    tick();
    check("t4_timeout_at_limit", 64'(timeout), 64'd1);
    repeat (3) tick();
    check("t4_timeout_sticky", 64'(timeout), 64'd1);
    check("t4_bready_held", 64'(bready), 64'd1);
    b_force     = 1'b1;
    b_force_val = DECERR;
    b_hold      = 1'b0;
    wait_done("t4", 40, lat, awc, wc, eb, am);
    check("t4_timeout_after_done", 64'(timeout), 64'd1);
    b_force = 1'b0;
    do_req(32'h44, 32'h11111111, 4'hF, 3'b000, OKAY);
    check("t4_timeout_cleared", 64'(timeout), 64'd0);
    wait_done("t4b", 40, lat, awc, wc, eb, am);
    $display("txn t4 addr=40 resp=%0d", DECERR);

    // 5: reset while in RESP
    b_hold = 1'b1;
    do_req(32'h50, 32'h22222222, 4'hF, 3'b000, OKAY);
    tick();
    check("t5_in_resp", 64'(bready), 64'd1);
    aresetn = 1'b0;
    #1;
    check("t5_rst_awvalid", 64'(awvalid), 64'd0);
    check("t5_rst_wvalid", 64'(wvalid), 64'd0);
    check("t5_rst_bready", 64'(bready), 64'd0);
    check("t5_rst_done", 64'(done), 64'd0);
    sb_q.delete();
    tick();
    aresetn = 1'b1;
    b_hold  = 1'b0;
    d0 = done_total;
    tick();
    check("t5_req_ready", 64'(req_ready), 64'd1);
    repeat (2) tick();
    check("t5_no_done", 64'(done_total - d0), 64'd0);
    do_req(32'h20, 32'h33333333, 4'hF, 3'b000, OKAY);
    wait_done("t5", 40, lat, awc, wc, eb, am);
    $display("txn t5 addr=20 resp=%0d", resp);

    // 6: req_valid held across two requests, toggled during SEND
    aw_stall_cfg = 2;
    d0 = done_total;
    a0 = aw_hs_total;
    w0 = w_hs_total;
    req_addr  = 32'h60;
    req_data  = 32'h66666666;
    req_strb  = 4'hF;
    req_valid = 1'b1;
    tick();
    sb_q.push_back(OKAY);
    check("t6_a_awaddr", 64'(awaddr), 64'h60);
    req_addr  = 32'h64;
    req_data  = 32'h77777777;
    req_valid = 1'b0;
    tick();
    check("t6_send_awaddr1", 64'(awaddr), 64'h60);
    check("t6_send_req_ready", 64'(req_ready), 64'd0);
    req_valid = 1'b1;
    tick();
    check("t6_send_awaddr2", 64'(awaddr), 64'h60);
    wait_done("t6a", 40, lat, awc, wc, eb, am);
    req_valid = 1'b0;
    sb_q.push_back(OKAY);
    check("t6_b_awvalid", 64'(awvalid), 64'd1);
    check("t6_b_awaddr", 64'(awaddr), 64'h64);
    wait_done("t6b", 40, lat, awc, wc, eb, am);
    check("t6_aw_beats", 64'(aw_hs_total - a0), 64'd2);
    check("t6_w_beats", 64'(w_hs_total - w0), 64'd2);
    check("t6_done_count", 64'(done_total - d0), 64'd2);
    aw_stall_cfg = 0;
    $display("txn t6 two requests dones=%0d", done_total - d0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
